mem_wb_stage: RTL and testbench

- MEM/WB pipeline register and load-data formatter for the 5-stage RV32I pipeline.
- Captures the MEM-stage result and selects the writeback source: ALU result, formatted load data, or PC+4.
- Drives the register file write port with WB_out, addD and RegWrite.
- Also supplies WB_out / addD / RegWrite to the EX forwarding unit.

---
 rtl/mem_wb_stage_if.sv | 35 +++
 rtl/mem_wb_stage.sv | 115 +++++++++++
 tb/tb_mem_wb_stage.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-stage capture inputs and writeback/forwarding outputs.
// master = MEM-stage side (drives the capture inputs), slave = the WB stage.
interface mem_wb_stage_if #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
);
   logic             stall;
   logic             flush;
   logic             in_valid;
   logic [RADDR-1:0] in_rd;
   logic             in_reg_write;
   logic [1:0]       in_wb_sel;
   logic [2:0]       in_funct3;
   logic [XLEN-1:0]  in_alu_result;
   logic [XLEN-1:0]  in_mem_rdata;
   logic [XLEN-1:0]  in_pc_plus4;
   logic [XLEN-1:0]  WB_out;
   logic [RADDR-1:0] addD;
   logic             RegWrite;
   logic             wb_valid;
   logic             load_fault;
   logic [31:0]      retire_count;

   modport master (
      output stall, flush, in_valid, in_rd, in_reg_write, in_wb_sel, in_funct3,
             in_alu_result, in_mem_rdata, in_pc_plus4,
      input  WB_out, addD, RegWrite, wb_valid, load_fault, retire_count
   );

   modport slave (
      input  stall, flush, in_valid, in_rd, in_reg_write, in_wb_sel, in_funct3,
             in_alu_result, in_mem_rdata, in_pc_plus4,
      output WB_out, addD, RegWrite, wb_valid, load_fault, retire_count
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with RV32I load-data formatting and writeback
// source selection. Optional retired-instruction counter enabled by the
// macro WB_RETIRE_CNT_EN; without it retire_count is tied to zero.
module mem_wb_stage #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
) (
   input logic           clk,
   input logic           rst,
   mem_wb_stage_if.slave bus
);

   typedef enum logic [1:0] {
      SEL_ALU  = 2'b00,
      SEL_LOAD = 2'b01,
      SEL_PC4  = 2'b10,
      SEL_RSVD = 2'b11
   } wb_sel_e;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } funct3_e;

   logic [1:0]       off;
   logic [XLEN-1:0]  shifted;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [XLEN-1:0]  sel_data;
   logic             fault_d;
   logic             rw_d;

   logic             valid_q;
   logic [RADDR-1:0] rd_q;
   logic [XLEN-1:0]  data_q;
   logic             rw_q;
   logic             fault_q;
   logic             done_q;

   // Writeback source selection and load formatting ahead of the register.
   always_comb begin
      off      = bus.in_alu_result[1:0];
      shifted  = bus.in_mem_rdata >> {off, 3'b000};
      byte_v   = shifted[7:0];
      half_v   = shifted[15:0];
      sel_data = '0;
      fault_d  = 1'b0;
      rw_d     = bus.in_reg_write;
      case (bus.in_wb_sel)
         SEL_ALU:  sel_data = bus.in_alu_result;
         SEL_PC4:  sel_data = bus.in_pc_plus4;
         SEL_LOAD: begin
            case (bus.in_funct3)
               F3_LB:  sel_data = {{(XLEN-8){byte_v[7]}}, byte_v};
               F3_LBU: sel_data = {{(XLEN-8){1'b0}}, byte_v};
               F3_LH:  if (off[0]) fault_d = 1'b1;
                       else sel_data = {{(XLEN-16){half_v[15]}}, half_v};
               F3_LHU: if (off[0]) fault_d = 1'b1;
                       else sel_data = {{(XLEN-16){1'b0}}, half_v};
               F3_LW:  if (off != 2'b00) fault_d = 1'b1;
                       else sel_data = bus.in_mem_rdata;
               default: fault_d = 1'b1;
            endcase
         end
         default:  rw_d = 1'b0;
      endcase
   end

   // Pipeline register: flush kills, stall holds and marks the entry done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
         rw_q    <= 1'b0;
         fault_q <= 1'b0;
         done_q  <= 1'b0;
      end else if (bus.flush || !bus.stall) begin
         valid_q <= bus.in_valid & ~bus.flush;
         rd_q    <= bus.in_rd;
         data_q  <= sel_data;
         rw_q    <= rw_d;
         fault_q <= fault_d;
         done_q  <= 1'b0;
      end else begin
         done_q  <= done_q | valid_q;
      end
   end

   assign bus.WB_out     = data_q;
   assign bus.addD       = rd_q;
   assign bus.wb_valid   = valid_q;
   assign bus.RegWrite   = valid_q & rw_q & (rd_q != '0) & ~fault_q & ~done_q;
   assign bus.load_fault = valid_q & fault_q & ~done_q;

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_q;

   // Count each live entry once, on its first edge in WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         retire_q <= '0;
      else if (valid_q && !done_q)
         retire_q <= retire_q + 32'd1;
   end

   assign bus.retire_count = retire_q;
`else
   assign bus.retire_count = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed test-plan cases with literal
// expectations, then randomized traffic against a record-level model.
module tb_mem_wb_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   mem_wb_stage_if #(.XLEN(32), .RADDR(5)) bus ();

   mem_wb_stage #(.XLEN(32), .RADDR(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Model of the instruction currently sitting in WB.
   logic        m_valid = 1'b0;
   logic [4:0]  m_rd    = '0;
   logic [31:0] m_data  = '0;
   logic        m_write = 1'b0;
   logic        m_fault = 1'b0;
   logic        m_used  = 1'b0;
   logic [31:0] m_count = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // What a MEM-stage instruction should write back, from the ISA rules.
   function automatic logic [31:0] wb_value(input logic [1:0] sel, input logic [2:0] f3,
                                            input logic [31:0] addr, input logic [31:0] rdata,
                                            input logic [31:0] pc, output logic fault);
      int unsigned off;
      logic [31:0] v;
      off   = addr % 4;
      fault = 1'b0;
      v     = 32'd0;
      if (sel == 2'd0) v = addr;
      else if (sel == 2'd2) v = pc;
      else if (sel == 2'd1) begin
         if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (rdata >> (8 * off)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
         end else if (f3 == 3'd1 || f3 == 3'd5) begin
            if (off % 2 != 0) fault = 1'b1;
            else begin
               v = (rdata >> (8 * off)) & 32'hFFFF;
               if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
         end else if (f3 == 3'd2) begin
            if (off != 0) fault = 1'b1;
            else v = rdata;
         end else fault = 1'b1;
      end
      return v;
   endfunction

   // Model update on each edge (or asynchronous reset).
   always @(posedge clk or posedge rst) begin
      logic f;
      logic [31:0] d;
      if (rst) begin
         m_valid = 1'b0; m_rd = '0; m_data = '0; m_write = 1'b0;
         m_fault = 1'b0; m_used = 1'b0; m_count = '0;
      end else begin
`ifdef WB_RETIRE_CNT_EN
         if (m_valid && !m_used) m_count = m_count + 32'd1;
`endif
         if (bus.flush) begin
            m_valid = 1'b0;
            m_used  = 1'b0;
         end else if (bus.stall) begin
            if (m_valid) m_used = 1'b1;
         end else begin
            d       = wb_value(bus.in_wb_sel, bus.in_funct3, bus.in_alu_result,
                               bus.in_mem_rdata, bus.in_pc_plus4, f);
            m_valid = bus.in_valid;
            m_rd    = bus.in_rd;
            m_data  = d;
            m_fault = f;
            m_write = bus.in_reg_write && bus.in_wb_sel != 2'd3;
            m_used  = 1'b0;
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("wb_valid", {31'd0, bus.wb_valid}, {31'd0, m_valid});
      chk("RegWrite", {31'd0, bus.RegWrite},
          {31'd0, m_valid && !m_used && m_write && !m_fault && m_rd != 5'd0});
      chk("load_fault", {31'd0, bus.load_fault}, {31'd0, m_valid && !m_used && m_fault});
      chk("retire_count", bus.retire_count, m_count);
      if (m_valid) begin
         chk("WB_out", bus.WB_out, m_data);
         chk("addD", {27'd0, bus.addD}, {27'd0, m_rd});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic v, input logic [4:0] rd, input logic rw,
                          input logic [1:0] sel, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] rdata,
                          input logic [31:0] pc);
      bus.in_valid      = v;
      bus.in_rd         = rd;
      bus.in_reg_write  = rw;
      bus.in_wb_sel     = sel;
      bus.in_funct3     = f3;
      bus.in_alu_result = alu;
      bus.in_mem_rdata  = rdata;
      bus.in_pc_plus4   = pc;
   endtask

   task automatic bubble();
      present(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] exp,
                          input string name);
      present(1'b1, 5'd3, 1'b1, 2'd1, f3, {30'h1000, off}, 32'h80FF_7F01, 32'h0);
      step();
      chk(name, bus.WB_out, exp);
   endtask

   initial begin
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bubble();
      step();
      step();
      chk("reset_WB_out", bus.WB_out, 32'd0);
      chk("reset_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
      chk("reset_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      rst = 1'b0;

      // ALU path
      present(1'b1, 5'd5, 1'b1, 2'd0, 3'd0, 32'h1234, 32'd0, 32'd0);
      step();
      chk("alu_WB_out", bus.WB_out, 32'h1234);
      chk("alu_addD", {27'd0, bus.addD}, 32'd5);
      chk("alu_RegWrite", {31'd0, bus.RegWrite}, 32'd1);
      bubble();
      step();
      chk("alu_RegWrite_once", {31'd0, bus.RegWrite}, 32'd0);

      // Load formatting
      do_load(3'b000, 2'd1, 32'h0000_007F, "lb_off1");
      do_load(3'b000, 2'd2, 32'hFFFF_FFFF, "lb_off2");
      do_load(3'b100, 2'd3, 32'h0000_0080, "lbu_off3");
      do_load(3'b001, 2'd2, 32'hFFFF_80FF, "lh_off2");
      do_load(3'b101, 2'd0, 32'h0000_7F01, "lhu_off0");
      do_load(3'b010, 2'd0, 32'h80FF_7F01, "lw_off0");

      // Faults
      do_load(3'b010, 2'd2, 32'd0, "lw_mis_WB_out");
      chk("lw_mis_fault", {31'd0, bus.load_fault}, 32'd1);
      chk("lw_mis_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
      do_load(3'b011, 2'd0, 32'd0, "ill_WB_out");
      chk("ill_fault", {31'd0, bus.load_fault}, 32'd1);
      chk("ill_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
      bubble();
      step();
      chk("fault_pulse_end", {31'd0, bus.load_fault}, 32'd0);

      // Stall holds an entry and writes once
      present(1'b1, 5'd7, 1'b1, 2'd0, 3'd0, 32'hABCD, 32'd0, 32'd0);
      step();
      chk("stall_first_RegWrite", {31'd0, bus.RegWrite}, 32'd1);
      bus.stall = 1'b1;
      present(1'b1, 5'd2, 1'b1, 2'd0, 3'd0, 32'h1111, 32'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
         chk("stall_WB_out", bus.WB_out, 32'hABCD);
         chk("stall_addD", {27'd0, bus.addD}, 32'd7);
      end
      bus.stall = 1'b0;

      // Flush beats stall
      present(1'b1, 5'd4, 1'b1, 2'd0, 3'd0, 32'h44, 32'd0, 32'd0);
      step();
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      step();
      chk("flush_stall_valid", {31'd0, bus.wb_valid}, 32'd0);
      bus.stall = 1'b0;
      bus.flush = 1'b0;

      // x0 never written
      present(1'b1, 5'd0, 1'b1, 2'd0, 3'd0, 32'h99, 32'd0, 32'd0);
      step();
      chk("x0_RegWrite", {31'd0, bus.RegWrite}, 32'd0);

      // Reset in the middle of a stall
      present(1'b1, 5'd9, 1'b1, 2'd0, 3'd0, 32'h55, 32'd0, 32'd0);
      step();
      bus.stall = 1'b1;
      step();
      #2 rst = 1'b1;
      #1;
      chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      chk("rst_WB_out", bus.WB_out, 32'd0);
      chk("rst_addD", {27'd0, bus.addD}, 32'd0);
      chk("rst_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
      chk("rst_retire", bus.retire_count, 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("post_rst_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
      bus.stall = 1'b0;
      bubble();
      step();
      chk("post_rst_valid", {31'd0, bus.wb_valid}, 32'd0);

      // Retire counting: 4 valid entries, one stalled 2 cycles, one bubble
      present(1'b1, 5'd1, 1'b1, 2'd0, 3'd0, 32'd1, 32'd0, 32'd0);
      step();
      present(1'b1, 5'd2, 1'b1, 2'd0, 3'd0, 32'd2, 32'd0, 32'd0);
      step();
      bus.stall = 1'b1;
      step();
      step();
      bus.stall = 1'b0;
      present(1'b1, 5'd3, 1'b0, 2'd3, 3'd0, 32'd3, 32'd0, 32'd0);
      step();
      bubble();
      step();
      present(1'b1, 5'd4, 1'b1, 2'd1, 3'd2, 32'd2, 32'd0, 32'd0);
      step();
      bubble();
      step();
`ifdef WB_RETIRE_CNT_EN
      chk("retire_four", bus.retire_count, 32'd4);
`else
      chk("retire_tied", bus.retire_count, 32'd0);
`endif

      // Randomized traffic checked by the model on every cycle
      for (int i = 0; i < 3000; i++) begin
         present($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                 $urandom_range(0, 4) != 0,
                 ($urandom_range(0, 1) == 0) ? 2'd1 : 2'($urandom),
                 ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)),
                 $urandom, $urandom, $urandom);
         bus.stall = $urandom_range(0, 3) == 0;
         bus.flush = $urandom_range(0, 9) == 0;
         rst       = $urandom_range(0, 199) == 0;
         step();
      end
      rst = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bubble();
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
